// File: rtl/rx_huge_page_sched_pkg.sv
// Shared state encoding and constants for the RX huge-page ping-pong scheduler.
package rx_huge_page_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_CLOSE  = 2'd2
  } sched_state_t;

  localparam int QW_SHIFT        = 3;
  localparam int DEF_PAGE_QW     = 262144;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/rx_huge_page_sched_if.sv
// Page-ownership, request/grant and close bundle between the address block, the RX engine and the scheduler.
interface rx_huge_page_sched_if
  import rx_huge_page_pkg::*;
#(
  parameter int PAGE_QW = DEF_PAGE_QW
) ();
  localparam int CQ_W = $clog2(PAGE_QW) + 1;

  logic [63:0]     huge_page_addr_1;
  logic [63:0]     huge_page_addr_2;
  logic            huge_page_status_1;
  logic            huge_page_status_2;
  logic            huge_page_free_1;
  logic            huge_page_free_2;
  logic            req_valid;
  logic [8:0]      req_qw;
  logic            req_ready;
  logic            grant_valid;
  logic [63:0]     grant_addr;
  logic            close_valid;
  logic [CQ_W-1:0] close_qw;
  logic            close_sel;

  modport slave (
    input  huge_page_addr_1, huge_page_addr_2, huge_page_status_1, huge_page_status_2,
    input  req_valid, req_qw,
    output huge_page_free_1, huge_page_free_2, req_ready,
    output grant_valid, grant_addr, close_valid, close_qw, close_sel
  );

  modport master (
    output huge_page_addr_1, huge_page_addr_2, huge_page_status_1, huge_page_status_2,
    output req_valid, req_qw,
    input  huge_page_free_1, huge_page_free_2, req_ready,
    input  grant_valid, grant_addr, close_valid, close_qw, close_sel
  );

endinterface

// File: rtl/rx_huge_page_sched_timer.sv
// Idle timer: loads TIMEOUT_CYC-1 on restart and counts down while enabled, parking at zero.
module rx_idle_timer
  import rx_huge_page_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_restart) begin
      r_count <= LOAD;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/rx_huge_page_sched.sv
// Ping-pong scheduler handing out qword-aligned write addresses from two host huge pages.
module rx_huge_page_sched
  import rx_huge_page_pkg::*;
#(
  parameter int PAGE_QW     = DEF_PAGE_QW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic                 trn_clk,
  input logic                 reset,
  rx_huge_page_sched_if.slave bus
);
  localparam int OFF_W = $clog2(PAGE_QW) + 1;
  // The sum must hold both a full offset and the 9-bit request without wrapping.
  localparam int SUM_W = ((OFF_W > 9) ? OFF_W : 9) + 1;

  sched_state_t     r_state;
  logic             r_cur;
  logic [OFF_W-1:0] r_offset;
  logic [63:0]      r_base;
  logic             r_grant_valid;
  logic [63:0]      r_grant_addr;
  logic             r_close_valid;
  logic [OFF_W-1:0] r_close_qw;
  logic             r_close_sel;
  logic             r_free_1;
  logic             r_free_2;

  logic             w_active;
  logic [SUM_W-1:0] w_sum;
  logic             w_fits;
  logic             w_accept;
  logic             w_expired;
  logic             w_timeout;
  logic             w_close_now;
  logic [OFF_W-1:0] w_close_qw;
  logic             w_status_cur;
  logic [63:0]      w_addr_cur;

  assign w_active      = (r_state == ST_ACTIVE);
  assign w_sum         = SUM_W'(r_offset) + SUM_W'(bus.req_qw);
  assign w_fits        = (w_sum <= SUM_W'(PAGE_QW));
  assign bus.req_ready = w_active && w_fits && !reset;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_timeout     = (r_offset != '0) && w_expired;
  assign w_status_cur  = r_cur ? bus.huge_page_status_2 : bus.huge_page_status_1;
  assign w_addr_cur    = r_cur ? bus.huge_page_addr_2 : bus.huge_page_addr_1;

  // An accept always beats a timeout; only an exact fill closes the page on an accept.
  assign w_close_now = w_accept ? (w_sum == SUM_W'(PAGE_QW)) : ((bus.req_valid && !w_fits) || w_timeout);
  assign w_close_qw  = w_accept ? w_sum[OFF_W-1:0] : r_offset;

  rx_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk       (trn_clk),
    .reset     (reset),
    .i_restart (!w_active || w_accept),
    .i_enable  (w_active && (r_offset != '0)),
    .o_expired (w_expired)
  );

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cur         <= 1'b0;
      r_offset      <= '0;
      r_base        <= '0;
      r_grant_valid <= 1'b0;
      r_grant_addr  <= '0;
      r_close_valid <= 1'b0;
      r_close_qw    <= '0;
      r_close_sel   <= 1'b0;
      r_free_1      <= 1'b0;
      r_free_2      <= 1'b0;
    end else begin
      r_grant_valid <= 1'b0;
      r_close_valid <= 1'b0;
      r_free_1      <= 1'b0;
      r_free_2      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_status_cur) begin
            r_base   <= w_addr_cur;
            r_offset <= '0;
            r_state  <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_accept) begin
            r_offset      <= w_sum[OFF_W-1:0];
            r_grant_valid <= 1'b1;
            r_grant_addr  <= r_base + (64'(r_offset) << QW_SHIFT);
          end
          if (w_close_now) begin
            r_state       <= ST_CLOSE;
            r_close_valid <= 1'b1;
            r_close_qw    <= w_close_qw;
            r_close_sel   <= r_cur;
            r_free_1      <= ~r_cur;
            r_free_2      <= r_cur;
          end
        end
        ST_CLOSE: begin
          r_cur   <= ~r_cur;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant_valid      = r_grant_valid;
  assign bus.grant_addr       = r_grant_addr;
  assign bus.close_valid      = r_close_valid;
  assign bus.close_qw         = r_close_qw;
  assign bus.close_sel        = r_close_sel;
  assign bus.huge_page_free_1 = r_free_1;
  assign bus.huge_page_free_2 = r_free_2;

  a_req_qw_nonzero: assert property (@(posedge trn_clk) disable iff (reset)
    bus.req_valid |-> (bus.req_qw != 9'd0));

endmodule

// File: tb/tb_rx_huge_page_sched.sv
// Bench for rx_huge_page_sched: directed page scenarios with literal checks, then randomized traffic against a page-fill model.
module tb_rx_huge_page_sched;
  localparam int PAGE_QW     = 64;
  localparam int TIMEOUT_CYC = 16;

  typedef struct {
    int sel;
    int qw;
  } closeEntry_t;

  logic trnClk;
  logic reset;

  rx_huge_page_sched_if #(.PAGE_QW(PAGE_QW)) bus ();

  rx_huge_page_sched #(
    .PAGE_QW     (PAGE_QW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .trn_clk (trnClk),
    .reset   (reset),
    .bus     (bus)
  );

  initial begin
    trnClk = 1'b0;
    forever #5 trnClk = ~trnClk;
  end

  int checkCount = 0;
  int failCount  = 0;

  // Page-fill model: which page is being filled, how much of it is used and how long it has sat idle.
  int          mPhase = 0;  // 0 waiting for the page, 1 filling, 2 handing it back
  int          mCur   = 0;
  int          mUsed  = 0;
  int          mIdle  = 0;
  logic [63:0] mBase  = '0;

  logic        eGrantValid = 1'b0;
  logic [63:0] eGrantAddr  = '0;
  logic        eCloseValid = 1'b0;
  int          eCloseQw    = 0;
  int          eCloseSel   = 0;
  logic        eFree1      = 1'b0;
  logic        eFree2      = 1'b0;

  logic [63:0] grantLog[$];
  closeEntry_t closeLog[$];
  bit          sawAccept, sawClose, sawFree1, sawFree2;
  bit          autoRearm = 0;
  int          rearm1 = 0;
  int          rearm2 = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareCycle();
    bit eReady;
    closeEntry_t entry;
    eReady = !reset && (mPhase == 1) && (mUsed + int'(bus.req_qw) <= PAGE_QW);
    checkOutput("req_ready", 64'(bus.req_ready), 64'(eReady));
    checkOutput("grant_valid", 64'(bus.grant_valid), 64'(eGrantValid));
    if (eGrantValid) checkOutput("grant_addr", bus.grant_addr, eGrantAddr);
    checkOutput("close_valid", 64'(bus.close_valid), 64'(eCloseValid));
    checkOutput("free_1", 64'(bus.huge_page_free_1), 64'(eFree1));
    checkOutput("free_2", 64'(bus.huge_page_free_2), 64'(eFree2));
    if (eCloseValid) begin
      checkOutput("close_qw", 64'(bus.close_qw), 64'(eCloseQw));
      checkOutput("close_sel", 64'(bus.close_sel), 64'(eCloseSel));
    end
    if (bus.grant_valid) grantLog.push_back(bus.grant_addr);
    if (bus.close_valid) begin
      entry.sel = int'(bus.close_sel);
      entry.qw  = int'(bus.close_qw);
      closeLog.push_back(entry);
    end
    sawAccept = bus.req_valid && bus.req_ready;
    sawClose  = bus.close_valid;
    sawFree1  = bus.huge_page_free_1;
    sawFree2  = bus.huge_page_free_2;
  endtask

  task automatic modelStep();
    int qw;
    bit closeNow;
    qw = int'(bus.req_qw);
    closeNow = 0;
    eGrantValid = 1'b0;
    eCloseValid = 1'b0;
    eFree1      = 1'b0;
    eFree2      = 1'b0;
    if (reset) begin
      mPhase = 0; mCur = 0; mUsed = 0; mIdle = 0;
      eGrantAddr = '0; eCloseQw = 0; eCloseSel = 0;
      return;
    end
    if (mPhase == 0) begin
      if ((mCur == 0) ? bus.huge_page_status_1 : bus.huge_page_status_2) begin
        mBase = (mCur == 0) ? bus.huge_page_addr_1 : bus.huge_page_addr_2;
        mUsed = 0; mIdle = 0; mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (bus.req_valid && (mUsed + qw <= PAGE_QW)) begin
        eGrantValid = 1'b1;
        eGrantAddr  = mBase + 64'(mUsed) * 64'd8;
        mUsed += qw;
        mIdle = 0;
        closeNow = (mUsed == PAGE_QW);
      end else if (bus.req_valid) begin
        closeNow = 1;
      end else if (mUsed > 0) begin
        if (mIdle == TIMEOUT_CYC - 1) closeNow = 1;
        else mIdle++;
      end
    end else begin
      mCur ^= 1;
      mPhase = 0;
    end
    if (closeNow) begin
      mPhase = 2;
      eCloseValid = 1'b1;
      eCloseQw = mUsed;
      eCloseSel = mCur;
      if (mCur == 0) eFree1 = 1'b1;
      else eFree2 = 1'b1;
    end
  endtask

  // Stand-in for the address block: a freed page drops its status on the next edge, optionally re-armed later.
  task automatic envStep();
    if (sawFree1) begin
      bus.huge_page_status_1 = 1'b0;
      rearm1 = autoRearm ? int'($urandom_range(1, 6)) : 0;
    end else if (rearm1 > 0) begin
      rearm1--;
      if (rearm1 == 0) begin
        bus.huge_page_addr_1   = {$urandom, $urandom} & ~64'h7;
        bus.huge_page_status_1 = 1'b1;
      end
    end
    if (sawFree2) begin
      bus.huge_page_status_2 = 1'b0;
      rearm2 = autoRearm ? int'($urandom_range(1, 6)) : 0;
    end else if (rearm2 > 0) begin
      rearm2--;
      if (rearm2 == 0) begin
        bus.huge_page_addr_2   = {$urandom, $urandom} & ~64'h7;
        bus.huge_page_status_2 = 1'b1;
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge trnClk);
    compareCycle();
    modelStep();
    @(posedge trnClk);
    #1;
    envStep();
  endtask

  task automatic applyStimulus(input int qw, output int waitCycles);
    waitCycles = 0;
    bus.req_valid = 1'b1;
    bus.req_qw    = 9'(qw);
    do begin
      stepCycle();
      waitCycles++;
    end while (!sawAccept && waitCycles < 200);
    bus.req_valid = 1'b0;
    if (!sawAccept) checkOutput("req_accept_timeout", 64'(sawAccept), 64'd1);
  endtask

  task automatic waitClose(output int steps);
    steps = 0;
    do begin
      stepCycle();
      steps++;
    end while (!sawClose && steps < 60);
  endtask

  initial begin
    int w;
    int n;
    int gBase;
    int cBase;

    reset = 1'b1;
    bus.req_valid          = 1'b0;
    bus.req_qw             = 9'd1;
    bus.huge_page_status_1 = 1'b0;
    bus.huge_page_status_2 = 1'b0;
    bus.huge_page_addr_1   = 64'h1_0000_0000;
    bus.huge_page_addr_2   = 64'h2_0000_0000;
    @(posedge trnClk);
    #1;
    stepCycle();
    stepCycle();
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("rst_grant_valid", 64'(bus.grant_valid), 64'd0);
    checkOutput("rst_grant_addr", bus.grant_addr, 64'd0);
    checkOutput("rst_close_valid", 64'(bus.close_valid), 64'd0);
    checkOutput("rst_close_qw", 64'(bus.close_qw), 64'd0);
    checkOutput("rst_close_sel", 64'(bus.close_sel), 64'd0);
    checkOutput("rst_free_1", 64'(bus.huge_page_free_1), 64'd0);
    checkOutput("rst_free_2", 64'(bus.huge_page_free_2), 64'd0);
    reset = 1'b0;
    repeat (4) stepCycle();

    // Page 1 only: three 8-qw grants, then fill it exactly with five more.
    bus.huge_page_status_1 = 1'b1;
    gBase = grantLog.size();
    cBase = closeLog.size();
    repeat (3) applyStimulus(8, w);
    stepCycle();
    checkOutput("grant_p1_0", grantLog[gBase], 64'h1_0000_0000);
    checkOutput("grant_p1_1", grantLog[gBase + 1], 64'h1_0000_0040);
    checkOutput("grant_p1_2", grantLog[gBase + 2], 64'h1_0000_0080);
    bus.huge_page_status_2 = 1'b1;
    repeat (5) applyStimulus(8, w);
    applyStimulus(8, w);
    checkOutput("switch_gap_cycles", 64'(w), 64'd3);
    stepCycle();
    checkOutput("grant_p1_last", grantLog[gBase + 7], 64'h1_0000_01C0);
    checkOutput("close_full_qw", 64'(closeLog[cBase].qw), 64'd64);
    checkOutput("close_full_sel", 64'(closeLog[cBase].sel), 64'd0);
    checkOutput("grant_p2_first", grantLog[gBase + 8], 64'h2_0000_0000);

    // Idle timeout on page 2 with page 1 still owned by the driver.
    cBase = closeLog.size();
    waitClose(n);
    checkOutput("timeout_cycles", 64'(n), 64'd16);
    checkOutput("timeout_qw", 64'(closeLog[cBase].qw), 64'd8);
    checkOutput("timeout_sel", 64'(closeLog[cBase].sel), 64'd1);
    repeat (3) stepCycle();
    checkOutput("wait_ready_low", 64'(bus.req_ready), 64'd0);

    // Page 1 returns at a new base; the base must be re-latched.
    bus.huge_page_addr_1   = 64'h1_0020_0000;
    bus.huge_page_status_1 = 1'b1;
    gBase = grantLog.size();
    applyStimulus(4, w);
    stepCycle();
    checkOutput("reopen_cycles", 64'(w), 64'd2);
    checkOutput("relatch_grant", grantLog[gBase], 64'h1_0020_0000);
    repeat (14) stepCycle();
    cBase = closeLog.size();
    applyStimulus(8, w);
    stepCycle();
    checkOutput("expiry_accept_cycles", 64'(w), 64'd1);
    checkOutput("expiry_no_close", 64'(closeLog.size()), 64'(cBase));
    checkOutput("expiry_grant", grantLog[gBase + 1], 64'h1_0020_0020);
    waitClose(n);
    checkOutput("timeout2_cycles", 64'(n), 64'd16);
    checkOutput("timeout2_qw", 64'(closeLog[cBase].qw), 64'd12);

    // Page 2 to offset 60, then an 8-qw request that no longer fits.
    bus.huge_page_addr_1   = 64'h1_0000_0000;
    bus.huge_page_status_2 = 1'b1;
    repeat (7) applyStimulus(8, w);
    applyStimulus(4, w);
    stepCycle();
    bus.huge_page_status_1 = 1'b1;
    gBase = grantLog.size();
    cBase = closeLog.size();
    applyStimulus(8, w);
    stepCycle();
    checkOutput("overflow_cycles", 64'(w), 64'd4);
    checkOutput("overflow_close_qw", 64'(closeLog[cBase].qw), 64'd60);
    checkOutput("overflow_close_sel", 64'(closeLog[cBase].sel), 64'd1);
    checkOutput("overflow_regrant", grantLog[gBase], 64'h1_0000_0000);

    // Reset at offset 24 of page 1: outputs clear and no free is issued.
    repeat (2) applyStimulus(8, w);
    reset = 1'b1;
    stepCycle();
    checkOutput("midrst_grant_valid", 64'(bus.grant_valid), 64'd0);
    checkOutput("midrst_grant_addr", bus.grant_addr, 64'd0);
    checkOutput("midrst_close_valid", 64'(bus.close_valid), 64'd0);
    checkOutput("midrst_free_1", 64'(bus.huge_page_free_1), 64'd0);
    reset = 1'b0;
    cBase = closeLog.size();
    repeat (5) stepCycle();
    checkOutput("midrst_no_close", 64'(closeLog.size()), 64'(cBase));
    gBase = grantLog.size();
    applyStimulus(8, w);
    stepCycle();
    checkOutput("midrst_regrant", grantLog[gBase], 64'h1_0000_0000);

    // Randomized traffic with the address block re-arming pages after random delays.
    autoRearm = 1;
    bus.huge_page_status_1 = 1'b1;
    bus.huge_page_status_2 = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset = ((cyc % 400) == 399);
      bus.req_valid = ((cyc % 160) < 130) && ($urandom_range(0, 3) != 0);
      bus.req_qw = ($urandom_range(0, 29) == 0) ? 9'($urandom_range(1, 256)) : 9'($urandom_range(1, 24));
      stepCycle();
    end
    reset = 1'b0;
    bus.req_valid = 1'b0;
    repeat (4) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
